// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX operand stage: source select, RAW forwarding/stall, ALU operand register.
// Optional feature macro: ARCABUCO_OPERAND_FWD_EN (EX/MEM forwarding; undefined = stall-only hazard resolution).

package arcabuco_core_pack;
   typedef enum logic [3:0] {
      alu_add, alu_sub, alu_and, alu_or, alu_xor,
      alu_sll, alu_srl, alu_sra, alu_slt, alu_sltu
   } t_alu_opcode;
endpackage

module ex_operand_stage
   import arcabuco_core_pack::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              id_valid,
   output logic              id_ready,
   input  t_alu_opcode       id_alu_op,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [4:0]        id_rs1_addr,
   input  logic [4:0]        id_rs2_addr,
   input  logic [4:0]        id_rd_addr,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic              id_src1_sel,
   input  logic              id_src2_sel,
   input  logic              id_rd_we,
   input  logic              id_is_load,
   input  logic [XLEN-1:0]   ex_fwd_data,
   input  logic              mem_fwd_we,
   input  logic [4:0]        mem_fwd_rd,
   input  logic [XLEN-1:0]   mem_fwd_data,
   output logic              ex_valid,
   input  logic              ex_ready,
   output t_alu_opcode       ex_alu_op,
   output logic [XLEN-1:0]   ex_in_1,
   output logic [XLEN-1:0]   ex_in_2,
   output logic [XLEN-1:0]   ex_rs2_val,
   output logic [XLEN-1:0]   ex_pc,
   output logic [4:0]        ex_rd_addr,
   output logic              ex_rd_we,
   output logic              ex_is_load
);

   typedef enum logic {st_empty, st_full} t_state;
   t_state state;

   logic            rs1_nz, rs2_nz;
   logic            load_use, hazard, accept;
   logic [XLEN-1:0] rs1_res, rs2_res;

   assign ex_valid = (state == st_full);
   assign rs1_nz   = id_rs1_used & (id_rs1_addr != 5'd0);
   assign rs2_nz   = id_rs2_used & (id_rs2_addr != 5'd0);

   // A load's data only exists once it reaches MEM, so a dependent must wait one cycle.
   assign load_use = ex_valid & ex_is_load & (ex_rd_addr != 5'd0) &
                     ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                      (id_rs2_used & (id_rs2_addr == ex_rd_addr)));

`ifdef ARCABUCO_OPERAND_FWD_EN
   logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;

   assign ex_hit1  = ex_valid & ex_rd_we & ~ex_is_load & (ex_rd_addr == id_rs1_addr);
   assign ex_hit2  = ex_valid & ex_rd_we & ~ex_is_load & (ex_rd_addr == id_rs2_addr);
   assign mem_hit1 = mem_fwd_we & (mem_fwd_rd == id_rs1_addr);
   assign mem_hit2 = mem_fwd_we & (mem_fwd_rd == id_rs2_addr);

   assign rs1_res = (id_rs1_addr == 5'd0) ? '0 :
                    ex_hit1  ? ex_fwd_data  :
                    mem_hit1 ? mem_fwd_data : id_rs1_data;
   assign rs2_res = (id_rs2_addr == 5'd0) ? '0 :
                    ex_hit2  ? ex_fwd_data  :
                    mem_hit2 ? mem_fwd_data : id_rs2_data;

   assign hazard = load_use;
`else
   logic dep1, dep2;
   logic unused_fwd;

   // Without bypass paths, any in-flight producer of a source blocks issue until written back.
   assign dep1 = (ex_valid & ex_rd_we & (ex_rd_addr == id_rs1_addr)) |
                 (mem_fwd_we & (mem_fwd_rd == id_rs1_addr));
   assign dep2 = (ex_valid & ex_rd_we & (ex_rd_addr == id_rs2_addr)) |
                 (mem_fwd_we & (mem_fwd_rd == id_rs2_addr));

   assign rs1_res = (id_rs1_addr == 5'd0) ? '0 : id_rs1_data;
   assign rs2_res = (id_rs2_addr == 5'd0) ? '0 : id_rs2_data;

   assign hazard     = load_use | (rs1_nz & dep1) | (rs2_nz & dep2);
   assign unused_fwd = ^{ex_fwd_data, mem_fwd_data};
`endif

   assign id_ready = flush | (~rst & ~hazard & (~ex_valid | ex_ready));
   assign accept   = id_valid & id_ready & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= st_empty;
         ex_alu_op  <= alu_add;
         ex_in_1    <= '0;
         ex_in_2    <= '0;
         ex_rs2_val <= '0;
         ex_pc      <= '0;
         ex_rd_addr <= 5'd0;
         ex_rd_we   <= 1'b0;
         ex_is_load <= 1'b0;
      end else if (flush) begin
         state <= st_empty;
      end else if (accept) begin
         state      <= st_full;
         ex_alu_op  <= id_alu_op;
         ex_in_1    <= id_src1_sel ? id_pc  : rs1_res;
         ex_in_2    <= id_src2_sel ? id_imm : rs2_res;
         ex_rs2_val <= rs2_res;
         ex_pc      <= id_pc;
         ex_rd_addr <= id_rd_addr;
         ex_rd_we   <= id_rd_we;
         ex_is_load <= id_is_load;
      end else if (ex_valid & ex_ready) begin
         state <= st_empty;
      end
   end

endmodule
